// File: rtl/mips_cpu_mem_arb_pkg.sv
// Shared types for the CPU fetch/data memory arbiter.
package mips_cpu_mem_arb_pkg;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;
endpackage

// File: rtl/mips_cpu_mem_arb_grant.sv
// Combinational grant selector for the memory arbiter.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate grants on a tie instead of
// always favouring the data port.
module mips_cpu_mem_arb_grant
  import mips_cpu_mem_arb_pkg::*;
(
  input  logic   instr_req,
  input  logic   data_req,
  input  owner_t last_grant,
  output owner_t owner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, the port that did not win last time gets the bus.
  always_comb begin
    owner = OWN_INSTR;
    if (data_req && !instr_req)
      owner = OWN_DATA;
    else if (data_req && instr_req)
      owner = (last_grant == OWN_DATA) ? OWN_INSTR : OWN_DATA;
  end
`else
  // Fixed priority has no use for grant history.
  logic unused_last;
  assign unused_last = (last_grant == OWN_DATA);

  // Data port always wins a tie.
  always_comb begin
    owner = OWN_INSTR;
    if (data_req)
      owner = OWN_DATA;
  end
`endif

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one waitrequest-style memory bus between the CPU fetch and data ports.
// Each transfer runs IDLE -> BUSY -> RESP; the owner sees a one-cycle
// waitrequest=0 window in RESP. Build option MEM_ARB_ROUND_ROBIN_EN selects
// round-robin tie-breaking (see mips_cpu_mem_arb_grant).
module mips_cpu_mem_arbiter
  import mips_cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_read,
  input  logic [ADDR_W-1:0] instr_address,
  output logic [DATA_W-1:0] instr_readdata,
  output logic              instr_waitrequest,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_writedata,
  input  logic [BE_W-1:0]   data_byteenable,
  output logic [DATA_W-1:0] data_readdata,
  output logic              data_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest
);

  state_t state;
  owner_t owner, last_grant, grant;
  logic   data_req;

  assign data_req = data_read | data_write;

  mips_cpu_mem_arb_grant u_grant (
    .instr_req  (instr_read),
    .data_req   (data_req),
    .last_grant (last_grant),
    .owner      (grant)
  );

  // A simultaneous load and store is a CPU bug; it is served as a store.
  a_rw_excl: assert property (@(posedge clk) disable iff (reset)
                              !(data_read && data_write));

  // Arbitration FSM; mem_* double as the latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      owner             <= OWN_INSTR;
      last_grant        <= OWN_DATA;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_address       <= '0;
      mem_writedata     <= '0;
      mem_byteenable    <= '0;
      instr_waitrequest <= 1'b1;
      data_waitrequest  <= 1'b1;
      instr_readdata    <= '0;
      data_readdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          instr_waitrequest <= 1'b1;
          data_waitrequest  <= 1'b1;
          if (instr_read || data_req) begin
            owner      <= grant;
            last_grant <= grant;
            state      <= BUSY;
            if (grant == OWN_DATA) begin
              mem_address    <= data_address;
              mem_writedata  <= data_writedata;
              mem_byteenable <= data_byteenable;
              mem_write      <= data_write;
              mem_read       <= !data_write;
            end else begin
              mem_address    <= instr_address;
              mem_byteenable <= '1;
              mem_write      <= 1'b0;
              mem_read       <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RESP;
            // A requester that gave up mid-transfer gets no response.
            if (owner == OWN_DATA) begin
              if (data_req) begin
                data_waitrequest <= 1'b0;
                if (mem_read)
                  data_readdata <= mem_readdata;
              end
            end else if (instr_read) begin
              instr_waitrequest <= 1'b0;
              instr_readdata    <= mem_readdata;
            end
          end
        end
        RESP: begin
          instr_waitrequest <= 1'b1;
          data_waitrequest  <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed, table-driven bench for mips_cpu_mem_arbiter with a stalling memory model.
module tb_mips_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic        data_read, data_write;
  logic [31:0] data_address, data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;
  logic [3:0]  mem_byteenable;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
  );

  // Memory model: fixed contents, stall_cfg wait cycles per access.
  int stall_cfg = 0;
  int stall_cnt = 0;
  int wr_cycles = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_be = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h24020005;
      32'h00000004: return 32'h00000011;
      32'h00000008: return 32'h00000022;
      default:      return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  assign mem_readdata    = mem_word(mem_address);
  assign mem_waitrequest = (mem_read | mem_write) && (stall_cnt < stall_cfg);

  always @(posedge clk) begin
    if (!(mem_read | mem_write) || !mem_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
    if (mem_write) wr_cycles <= wr_cycles + 1;
    if (mem_write && !mem_waitrequest) begin
      wr_addr <= mem_address;
      wr_data <= mem_writedata;
      wr_be   <= mem_byteenable;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_instr;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stalls;
    int          lat;     // cycle of waitrequest=0, request cycle counted as 1
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[7];

  // One transaction; starts and ends #1 after a posedge with the FSM idle.
  task automatic txn(input vec_t v, input string name);
    int n = 0;
    int wr0 = wr_cycles;
    logic other_hi = 1'b1;
    logic own_wait;
    stall_cfg = v.stalls;
    if (v.is_instr) begin
      instr_read = 1'b1; instr_address = v.addr;
    end else begin
      data_read = !v.is_write; data_write = v.is_write;
      data_address = v.addr; data_writedata = v.wdata; data_byteenable = v.be;
    end
    do begin
      @(posedge clk); #1; n++;
      own_wait = v.is_instr ? instr_waitrequest : data_waitrequest;
      if ((v.is_instr ? data_waitrequest : instr_waitrequest) !== 1'b1) other_hi = 1'b0;
    end while (own_wait && n < 20);
    chk({name, " latency"}, n + 1, v.lat);
    chk({name, " other_wait_high"}, {31'd0, other_hi}, 32'd1);
    if (v.is_instr) chk({name, " instr_readdata"}, instr_readdata, v.rdata);
    else if (!v.is_write) chk({name, " data_readdata"}, data_readdata, v.rdata);
    else begin
      chk({name, " wr_addr"}, wr_addr, v.addr);
      chk({name, " wr_data"}, wr_data, v.wdata);
      chk({name, " wr_be"}, {28'd0, wr_be}, {28'd0, v.be});
      chk({name, " wr_cycles"}, wr_cycles - wr0, v.stalls + 1);
    end
    instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    @(posedge clk); #1;
    chk({name, " window_one_cycle"}, {30'd0, instr_waitrequest, data_waitrequest}, 32'd3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int d_cyc, i_cyc;
  logic [31:0] d_val, i_val;
  logic stayed_hi;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'h0, 0, 3, 32'h24020005};
    vecs[1] = '{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 4'hF, 2, 5, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h00000004, 32'h0,        4'hF, 0, 3, 32'h00000011};
    vecs[3] = '{1'b0, 1'b0, 32'h00000008, 32'h0,        4'hF, 1, 4, 32'h00000022};
    vecs[4] = '{1'b1, 1'b0, 32'h00000100, 32'h0,        4'h0, 3, 6, 32'hA5A5A4A5};
    vecs[5] = '{1'b0, 1'b1, 32'h00000022, 32'h12345678, 4'h3, 0, 3, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h00000013, 32'h0,        4'hF, 0, 3, 32'hA5A5A5B6};

    reset = 1'b1;
    instr_read = 1'b0; instr_address = '0;
    data_read = 1'b0; data_write = 1'b0; data_address = '0;
    data_writedata = '0; data_byteenable = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_rd_wr", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst mem_address", mem_address, 32'd0);
    chk("rst mem_writedata", mem_writedata, 32'd0);
    chk("rst mem_be", {28'd0, mem_byteenable}, 32'd0);
    chk("rst waits", {30'd0, instr_waitrequest, data_waitrequest}, 32'd3);
    chk("rst readdata", instr_readdata | data_readdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle waits", {30'd0, instr_waitrequest, data_waitrequest}, 32'd3);

    for (int i = 0; i < 7; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous fetch and load straight out of reset.
    do_reset();
    stall_cfg = 0;
    instr_read = 1'b1; instr_address = 32'hBFC00000;
    data_read = 1'b1; data_address = 32'h4;
    d_cyc = 0; i_cyc = 0; d_val = '0; i_val = '0;
    for (int c = 2; c <= 14 && (d_cyc == 0 || i_cyc == 0); c++) begin
      @(posedge clk); #1;
      if (!data_waitrequest)  begin d_cyc = c; d_val = data_readdata;  data_read = 1'b0;  end
      if (!instr_waitrequest) begin i_cyc = c; i_val = instr_readdata; instr_read = 1'b0; end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie instr_cycle", i_cyc, 3);
    chk("tie data_cycle", d_cyc, 6);
`else
    chk("tie data_cycle", d_cyc, 3);
    chk("tie instr_cycle", i_cyc, 6);
`endif
    chk("tie data_val", d_val, 32'h11);
    chk("tie instr_val", i_val, 32'h24020005);
    instr_read = 1'b0; data_read = 1'b0;
    @(posedge clk); #1;

    // Reset while a stalled fetch is in flight.
    stall_cfg = 5;
    instr_read = 1'b1; instr_address = 32'h00000200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midbusy mem_read", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst mem_rd_wr", {30'd0, mem_read, mem_write}, 32'd0);
    chk("midrst waits", {30'd0, instr_waitrequest, data_waitrequest}, 32'd3);
    chk("midrst mem_address", mem_address, 32'd0);
    reset = 1'b0; instr_read = 1'b0; stall_cfg = 0;
    txn(vecs[0], "post_rst_fetch");

    // Fetch abandoned mid-transfer: the response must be swallowed.
    stall_cfg = 2;
    instr_read = 1'b1; instr_address = 32'h00000040;
    @(posedge clk); #1;
    instr_read = 1'b0;
    stayed_hi = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (instr_waitrequest !== 1'b1) stayed_hi = 1'b0;
    end
    chk("abandon wait_high", {31'd0, stayed_hi}, 32'd1);
    chk("abandon readdata_kept", instr_readdata, 32'h24020005);

    // Back-to-back loads: second request presented during the first's window.
    stall_cfg = 0;
    data_read = 1'b1; data_address = 32'h4;
    d_cyc = 0;
    for (int c = 2; c <= 20 && d_cyc == 0; c++) begin
      @(posedge clk); #1;
      if (!data_waitrequest) d_cyc = c;
    end
    chk("b2b first_cycle", d_cyc, 3);
    chk("b2b first_val", data_readdata, 32'h11);
    data_address = 32'h8;
    @(posedge clk); #1;
    chk("b2b first_window", {31'd0, data_waitrequest}, 32'd1);
    d_cyc = 0;
    for (int c = 2; c <= 20 && d_cyc == 0; c++) begin
      @(posedge clk); #1;
      if (!data_waitrequest) d_cyc = c;
    end
    chk("b2b second_cycle", d_cyc, 3);
    chk("b2b second_val", data_readdata, 32'h22);
    data_read = 1'b0;
    @(posedge clk); #1;
    chk("b2b second_window", {31'd0, data_waitrequest}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
